// File: rtl/pkt_rr_arbiter.sv
// Generic synchronous FIFO with occupancy count; head word presented combinationally.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; callers gate on count.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk156,
    input  logic          sys_rst_n,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop_rdy,
    output logic [W-1:0]  head_dat,
    output logic [CW-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push  = push_vld && (count != FULL);
    assign do_pop   = pop_rdy && (count != '0);
    assign head_dat = mem[rd_ptr];

    // Storage needs no reset: count gates every use of it.
    always_ff @(posedge clk156) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// Per-packet round-robin merge of two FWFT sources into one FWFT output, with overlength truncation.
// Latency: source seen non-empty in IDLE at cycle N, pushed at N+1, output non-empty at N+2.
// Backpressure: 2-word output buffer; source reads stop when it is full, 1 word/cycle sustained.
module pkt_rr_arbiter #(
    parameter int DATA_W    = 74,
    parameter int MAX_WORDS = 32
) (
    input  logic              clk156,
    input  logic              sys_rst_n,
    output logic              fifo0_rd_en,
    input  logic [DATA_W-1:0] fifo0_dout,
    input  logic              fifo0_empty,
    output logic              fifo1_rd_en,
    input  logic [DATA_W-1:0] fifo1_dout,
    input  logic              fifo1_empty,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic [31:0]       pkt_cnt0,
    output logic [31:0]       pkt_cnt1,
    output logic [15:0]       trunc_cnt
);
    localparam int TLAST_BIT = 72;
    localparam int TUSER_BIT = 73;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FWD     = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    localparam logic [15:0] WC_LAST = 16'(MAX_WORDS - 1);

    logic [1:0]        state;
    logic              gnt;
    logic              last_gnt;
    logic [15:0]       wc;
    logic [1:0]        buf_count;
    logic              src_empty;
    logic [DATA_W-1:0] src_dat;
    logic              src_last;
    logic              push_vld;
    logic [DATA_W-1:0] push_dat;
    logic              drop_vld;
    logic              pop_rdy;
    logic              trunc_hit;

    assign src_empty = gnt ? fifo1_empty : fifo0_empty;
    assign src_dat   = gnt ? fifo1_dout : fifo0_dout;
    assign src_last  = src_dat[TLAST_BIT];

    // Push decision uses the registered buffer count, so a full buffer never pushes even when popping.
    assign push_vld  = (state == ST_FWD) && !src_empty && (buf_count < 2'd2);
    assign drop_vld  = (state == ST_DISCARD) && !src_empty;
    assign trunc_hit = (wc == WC_LAST) && !src_last;

    assign fifo0_rd_en = !gnt && (push_vld || drop_vld);
    assign fifo1_rd_en =  gnt && (push_vld || drop_vld);

    assign pop_rdy = rd_en && !empty;
    assign empty   = (buf_count == 2'd0);

    always_comb begin
        push_dat = src_dat;
        if (trunc_hit) begin
            push_dat[TLAST_BIT] = 1'b1;
            push_dat[TUSER_BIT] = 1'b1;
        end
    end

    fifo #(
        .W     (DATA_W),
        .DEPTH (2)
    ) u_out_buf (
        .clk156    (clk156),
        .sys_rst_n (sys_rst_n),
        .push_vld  (push_vld),
        .push_dat  (push_dat),
        .pop_rdy   (pop_rdy),
        .head_dat  (dout),
        .count     (buf_count)
    );

    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= ST_IDLE;
            gnt       <= 1'b0;
            last_gnt  <= 1'b1;
            wc        <= '0;
            pkt_cnt0  <= '0;
            pkt_cnt1  <= '0;
            trunc_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wc <= '0;
                    if (!fifo0_empty && !fifo1_empty) begin
                        gnt   <= !last_gnt;
                        state <= ST_FWD;
                    end else if (!fifo0_empty) begin
                        gnt   <= 1'b0;
                        state <= ST_FWD;
                    end else if (!fifo1_empty) begin
                        gnt   <= 1'b1;
                        state <= ST_FWD;
                    end
                end
                ST_FWD: begin
                    if (push_vld) begin
                        wc <= wc + 16'd1;
                        if (trunc_hit || src_last) begin
                            if (gnt) begin
                                pkt_cnt1 <= pkt_cnt1 + 32'd1;
                            end else begin
                                pkt_cnt0 <= pkt_cnt0 + 32'd1;
                            end
                        end
                        if (trunc_hit) begin
                            state <= ST_DISCARD;
                            if (trunc_cnt != 16'hFFFF) begin
                                trunc_cnt <= trunc_cnt + 16'd1;
                            end
                        end else if (src_last) begin
                            state    <= ST_IDLE;
                            last_gnt <= gnt;
                        end
                    end
                end
                ST_DISCARD: begin
                    // Tail of an overlength packet is drained silently up to its real tlast.
                    if (drop_vld && src_last) begin
                        state    <= ST_IDLE;
                        last_gnt <= gnt;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
